qspi_ram_emu: RTL and testbench
===============================

QSPI_RAM_EMU -- requirements
Module: qspi_ram_emu

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width of the backing memory.
REQ-002 SHALL have parameter DUMMY, default 4, number of SCK cycles between the last address nibble and the first read data nibble.
REQ-003 clk  input  1  system clock, the same clock that drives the CPU; SCK is at most clk/4.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cs_n  input  1  QSPI chip select from the CPU, active-low, asynchronous to clk.
REQ-006 sck  input  1  QSPI serial clock from the CPU, asynchronous to clk.
REQ-007 io_in  input  4  QSPI data from the pads, asynchronous to clk.
REQ-008 io_out  output  4  QSPI read data to the pads.
REQ-009 io_oe  output  4  pad output enables; 1 = drive.
REQ-010 mem_addr  output  ADDR_W  backing RAM byte address.
REQ-011 mem_wdata  output  8  backing RAM write data.
REQ-012 mem_we  output  1  backing RAM write strobe, one clk wide.
REQ-013 mem_rdata  input  8  backing RAM read data, valid one clk after mem_addr changes.

Function
REQ-014 cs_n, sck and io_in SHALL each pass through a 2-flop synchronizer; SCK edges SHALL be detected on the synchronized signal, one clk pulse per edge.
REQ-015 All nibbles SHALL be sampled on a detected SCK rising edge and driven on a detected SCK falling edge, MS nibble first, with 4 bits per SCK cycle.
REQ-016 The FSM SHALL have the states IDLE, CMD, ADDR, DUMMY, RDATA, WDATA and IGNORE.
REQ-017 IDLE SHALL move to CMD when synchronized cs_n falls.
REQ-018 CMD SHALL collect 2 nibbles.
REQ-019 A command of 0xEB SHALL select a read and 0x38 SHALL select a write; any other command SHALL move to IGNORE.
REQ-020 ADDR SHALL collect 6 nibbles (24 bits); only the low ADDR_W bits SHALL be kept and the upper bits SHALL be ignored.
REQ-021 On a read, ADDR SHALL be followed by DUMMY, which counts DUMMY rising edges and then moves to RDATA.
REQ-022 On a read, mem_addr SHALL be loaded on entry to DUMMY.
REQ-023 RDATA SHALL drive mem_rdata[7:4] on the first falling edge and mem_rdata[3:0] on the next, then increment mem_addr.
REQ-024 The byte sequence in RDATA SHALL repeat until cs_n rises.
REQ-025 io_oe SHALL be 4'hF from the first RDATA falling edge until cs_n rises, and 0 at all other times.
REQ-026 On a write, ADDR SHALL be followed by WDATA.
REQ-027 Each pair of nibbles received in WDATA SHALL form a byte that is presented on mem_wdata with mem_addr, with mem_we high for exactly one clk, after which mem_addr increments.
REQ-028 If cs_n rises after an odd number of write nibbles, the partial byte SHALL be discarded and no write issued.
REQ-029 mem_addr increments SHALL wrap from 2^ADDR_W-1 to 0.
REQ-030 A synchronized cs_n rise SHALL return the FSM to IDLE from any state within 1 clk, clearing io_oe and the nibble counters.
REQ-031 When a cs_n rise and an SCK edge are detected in the same clk, the cs_n rise SHALL win and the edge SHALL be ignored.
REQ-032 IGNORE SHALL keep io_oe at 0 and never assert mem_we.
REQ-033 SCK edges while cs_n is high SHALL have no effect.

Reset
REQ-034 While rst_n is low: state = IDLE, io_out = 0, io_oe = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, all counters = 0, and synchronizers = idle values (cs_n 1, sck 0).
REQ-035 rst_n asserted mid-transaction SHALL abort it immediately.
REQ-036 After rst_n is released, the block SHALL wait for a fresh cs_n falling edge; a transaction already in progress SHALL be ignored.

Structure
REQ-037 Package vc_qspi_pkg SHALL hold the FSM state enum, the command constants 0xEB and 0x38, and the address nibble count 6.
REQ-038 One sub-module, qspi_sync_edge, SHALL hold the 2-flop synchronizer plus rise/fall pulse generation and be instantiated for sck and cs_n.
REQ-039 io_in SHALL use a plain 2-flop synchronizer.
REQ-040 Pad tristating SHALL remain outside this block.

Verification
REQ-041 Write test: cs_n low, SCK = clk/4, cmd 0x38, addr 0x000010, data 0xA5 0x3C, then cs_n high -> mem_we pulses twice: (0x0010, 0xA5) then (0x0011, 0x3C).
REQ-042 Read test: RAM preloaded with 0x0010 = 0xA5 and 0x0011 = 0x3C; cmd 0xEB, addr 0x000010, 4 dummy cycles, 4 data cycles -> io_out nibbles A,5,3,C, and io_oe = F only during the data cycles.
REQ-043 Wrap test: read at 0x00FFFF for 2 bytes -> bytes from 0xFFFF then 0x0000.
REQ-044 Bad-command test: cmd 0x9F followed by 16 SCK cycles -> io_oe stays 0 and mem_we stays 0; a following valid read behaves per REQ-042.
REQ-045 Abort test: cs_n high after 3 write nibbles -> exactly one write at the start address, and the next command decodes correctly.
REQ-046 Reset test: rst_n low mid-RDATA -> io_oe = 0 within the same clk, and io_oe stays 0 after release until a new cs_n falling edge.

Source files
------------

// File: rtl/vc_qspi_pkg.sv
// Shared definitions for the QSPI RAM emulator: FSM states, command opcodes and
// the address phase length.
package vc_qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } qspi_state_t;

  localparam logic [7:0] CMD_READ     = 8'hEB;
  localparam logic [7:0] CMD_WRITE    = 8'h38;
  localparam int         ADDR_NIBBLES = 6;

  function automatic qspi_state_t decode_cmd(input logic [7:0] cmd);
    case (cmd)
      CMD_READ, CMD_WRITE: return ST_ADDR;
      default:             return ST_IGNORE;
    endcase
  endfunction

endpackage

// File: rtl/qspi_sync_edge.sv
// Two-flop synchronizer with one-clk rise/fall pulses on the synchronized level.
// Edges are suppressed until the pipeline holds real samples, so a pin already
// at its active level when reset is released never looks like a fresh edge.
module qspi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic       s1_reg;
  logic       s2_reg;
  logic       prev_reg;
  logic [1:0] fill_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg   <= RST_VAL;
      s2_reg   <= RST_VAL;
      prev_reg <= RST_VAL;
      fill_reg <= 2'd0;
    end else begin
      s1_reg   <= d;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
      if (fill_reg != 2'd3) fill_reg <= fill_reg + 2'd1;
    end
  end

  assign rise = (fill_reg == 2'd3) &&  s2_reg && !prev_reg;
  assign fall = (fill_reg == 2'd3) && !s2_reg &&  prev_reg;

endmodule

// File: rtl/qspi_ram_emu.sv
// QSPI slave that emulates a byte-wide RAM: 0xEB quad read with dummy cycles,
// 0x38 quad write, everything sampled through synchronizers on the system clock.
module qspi_ram_emu #(
  parameter int ADDR_W = 16,
  parameter int DUMMY  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sck,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  import vc_qspi_pkg::*;

  localparam int DCW = (DUMMY < 2) ? 1 : $clog2(DUMMY);

  logic cs_rise, cs_fall, sck_rise, sck_fall;

  qspi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  qspi_sync_edge #(.RST_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sck),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  logic [3:0] io_s1_reg, io_s_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_s1_reg <= 4'h0;
      io_s_reg  <= 4'h0;
    end else begin
      io_s1_reg <= io_in;
      io_s_reg  <= io_s1_reg;
    end
  end

  qspi_state_t       state_reg;
  logic [2:0]        nib_cnt_reg;
  logic [DCW-1:0]    dummy_cnt_reg;
  logic              phase_reg;
  logic              is_read_reg;
  logic [3:0]        cmd_hi_reg;
  logic [3:0]        byte_hi_reg;
  logic [ADDR_W-5:0] addr_sr_reg;
  logic [ADDR_W-1:0] addr_next;

  // Only the low ADDR_W bits of the 24-bit address survive the shift.
  assign addr_next = {addr_sr_reg, io_s_reg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      nib_cnt_reg   <= '0;
      dummy_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      is_read_reg   <= 1'b0;
      cmd_hi_reg    <= '0;
      byte_hi_reg   <= '0;
      addr_sr_reg   <= '0;
      io_out        <= 4'h0;
      io_oe         <= 4'h0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      mem_we <= 1'b0;
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);

      // cs_n rising outranks any SCK edge seen in the same clk.
      if (cs_rise) begin
        state_reg     <= ST_IDLE;
        nib_cnt_reg   <= '0;
        dummy_cnt_reg <= '0;
        phase_reg     <= 1'b0;
        io_oe         <= 4'h0;
        io_out        <= 4'h0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cs_fall) begin
              state_reg   <= ST_CMD;
              nib_cnt_reg <= '0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              if (nib_cnt_reg == 3'd0) begin
                cmd_hi_reg  <= io_s_reg;
                nib_cnt_reg <= 3'd1;
              end else begin
                nib_cnt_reg <= '0;
                is_read_reg <= ({cmd_hi_reg, io_s_reg} == CMD_READ);
                state_reg   <= decode_cmd({cmd_hi_reg, io_s_reg});
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              addr_sr_reg <= addr_next[ADDR_W-5:0];
              if (nib_cnt_reg == 3'(ADDR_NIBBLES - 1)) begin
                nib_cnt_reg   <= '0;
                dummy_cnt_reg <= '0;
                phase_reg     <= 1'b0;
                mem_addr      <= addr_next;
                if (!is_read_reg)    state_reg <= ST_WDATA;
                else if (DUMMY == 0) state_reg <= ST_RDATA;
                else                 state_reg <= ST_DUMMY;
              end else begin
                nib_cnt_reg <= nib_cnt_reg + 3'd1;
              end
            end
          end
          ST_DUMMY: begin
            if (sck_rise) begin
              if (dummy_cnt_reg == DCW'(DUMMY - 1)) begin
                dummy_cnt_reg <= '0;
                state_reg     <= ST_RDATA;
              end else begin
                dummy_cnt_reg <= dummy_cnt_reg + DCW'(1);
              end
            end
          end
          ST_RDATA: begin
            if (sck_fall) begin
              io_oe <= 4'hF;
              if (!phase_reg) begin
                io_out    <= mem_rdata[7:4];
                phase_reg <= 1'b1;
              end else begin
                io_out    <= mem_rdata[3:0];
                phase_reg <= 1'b0;
                mem_addr  <= mem_addr + ADDR_W'(1);
              end
            end
          end
          ST_WDATA: begin
            if (sck_rise) begin
              if (!phase_reg) begin
                byte_hi_reg <= io_s_reg;
                phase_reg   <= 1'b1;
              end else begin
                mem_wdata <= {byte_hi_reg, io_s_reg};
                mem_we    <= 1'b1;
                phase_reg <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_ram_emu.sv
// Drives QSPI transactions at SCK = clk/4 against a behavioural RAM model and
// checks writes, read nibbles, wrap, bad commands, aborts and mid-read reset.
module tb_qspi_ram_emu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic        sck;
  logic [3:0]  io_in;
  logic [3:0]  io_out;
  logic [3:0]  io_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ram     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] wq_addr [$];
  logic [7:0]  wq_data [$];
  logic        oe_seen;
  logic [3:0]  smp_out, smp_oe;
  logic [7:0]  wbuf [0:7];
  logic [7:0]  tmp8;

  always #5 clk = ~clk;

  qspi_ram_emu #(.ADDR_W(16), .DUMMY(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .sck      (sck),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oe    (io_oe),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  // Backing RAM: registered read, write logging for the scoreboard.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we === 1'b1) begin
      ram[mem_addr] = mem_wdata;
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
    if (io_oe !== 4'h0) oe_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sck_cycle(input logic [3:0] nib);
    io_in = nib;
    repeat (2) @(negedge clk);
    sck = 1'b1;
    repeat (2) @(negedge clk);
    smp_out = io_out;
    smp_oe  = io_oe;
    sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    sck_cycle(b[7:4]);
    sck_cycle(b[3:0]);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr);
    send_byte(cmd);
    for (int i = 5; i >= 0; i--) sck_cycle(addr[i*4 +: 4]);
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_finish();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    oe_seen = 1'b0;
  endtask

  // Model: byte i lands at (start + i) mod 2^16.
  task automatic do_write(input logic [23:0] addr, input int n);
    logic [15:0] ea;
    clear_log();
    cs_begin();
    send_header(8'h38, addr);
    for (int i = 0; i < n; i++) send_byte(wbuf[i]);
    cs_finish();
    check("write count", wq_addr.size(), n);
    for (int i = 0; i < n && i < wq_addr.size(); i++) begin
      ea = 16'(addr + 24'(i));
      check("write addr", wq_addr[i], ea);
      check("write data", wq_data[i], wbuf[i]);
    end
    for (int i = 0; i < n; i++) ref_mem[16'(addr + 24'(i))] = wbuf[i];
    check("write oe", oe_seen, 1'b0);
  endtask

  task automatic do_read(input logic [23:0] addr, input int n);
    logic [7:0] b;
    logic [3:0] en;
    clear_log();
    cs_begin();
    send_header(8'hEB, addr);
    for (int d = 0; d < 4; d++) sck_cycle(4'($urandom));
    check("oe before data", oe_seen, 1'b0);
    for (int k = 0; k < 2 * n; k++) begin
      sck_cycle(4'($urandom));
      b  = ref_mem[16'(addr + 24'(k / 2))];
      en = (k % 2 == 0) ? b[7:4] : b[3:0];
      check("read nibble", smp_out, en);
      check("read oe", smp_oe, 4'hF);
    end
    cs_finish();
    check("oe after cs", io_oe, 4'h0);
    check("read no write", wq_addr.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sck   = 1'b0;
    io_in = 4'h0;
    oe_seen = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      tmp8 = 8'($urandom);
      ram[i]     = tmp8;
      ref_mem[i] = tmp8;
    end
    repeat (3) @(negedge clk);
    check("rst io_oe", io_oe, 4'h0);
    check("rst io_out", io_out, 4'h0);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, 16'h0);
    check("rst mem_wdata", mem_wdata, 8'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Directed write then read-back of the same two bytes.
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    do_write(24'h000010, 2);
    do_read(24'h000010, 2);

    // Address wrap on read and on write; upper address bits ignored.
    ram[16'hFFFF] = 8'h5E; ref_mem[16'hFFFF] = 8'h5E;
    ram[16'h0000] = 8'h71; ref_mem[16'h0000] = 8'h71;
    do_read(24'h00FFFF, 2);
    wbuf[0] = 8'hC3; wbuf[1] = 8'h96;
    do_write(24'h12FFFF, 2);
    do_read(24'hAB0010, 2);

    // Unknown command: no drive, no writes, then a normal read.
    clear_log();
    cs_begin();
    send_byte(8'h9F);
    for (int i = 0; i < 16; i++) sck_cycle(4'($urandom));
    cs_finish();
    check("badcmd oe", oe_seen, 1'b0);
    check("badcmd writes", wq_addr.size(), 0);
    do_read(24'h000010, 2);

    // Abort after three write nibbles: only the first byte lands.
    clear_log();
    cs_begin();
    send_header(8'h38, 24'h000200);
    sck_cycle(4'h6); sck_cycle(4'h9); sck_cycle(4'hD);
    cs_finish();
    check("abort count", wq_addr.size(), 1);
    if (wq_addr.size() > 0) begin
      check("abort addr", wq_addr[0], 16'h0200);
      check("abort data", wq_data[0], 8'h69);
    end
    ref_mem[16'h0200] = 8'h69;
    do_read(24'h000200, 1);

    // Reset in the middle of read data, with cs_n held low across release.
    clear_log();
    cs_begin();
    send_header(8'hEB, 24'h000010);
    for (int d = 0; d < 6; d++) sck_cycle(4'($urandom));
    check("pre-reset oe", io_oe, 4'hF);
    rst_n = 1'b0;
    #1;
    check("reset oe same clk", io_oe, 4'h0);
    check("reset io_out", io_out, 4'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    send_header(8'h38, 24'h000300);
    send_byte(8'hEE);
    sck_cycle(4'h1);
    check("post-reset oe", oe_seen, 1'b0);
    check("post-reset writes", wq_addr.size(), 0);
    cs_finish();
    do_read(24'h000010, 2);

    // Random write/read rounds against the model.
    for (int r = 0; r < 8; r++) begin
      logic [23:0] a;
      int n;
      a = 24'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      do_write(a, n);
      do_read(a, n + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
